tt_sweep_checker: RTL and testbench
===================================

# tt_sweep_checker

Sequential stimulus/capture stage wrapped around a synthesized 4-input truth-table gate netlist. On `start`, the block drives all 16 input combinations into the gate and samples the gate's single output for each. It rebuilds the 16-bit truth table in the design flow's hex convention and compares it against an expected value. Its outputs report pass/fail, the mismatch count and the first failing vector to the design-automation regression flow.

## Interface
- `EXPECTED_TT`, 16'h10C9: golden truth table, same hex convention as the flow's design names.
- `SETTLE`, 2: extra hold cycles per vector before sampling; legal range 0..255.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `vec_out`  out  4  gate inputs: `vec_out[3]`→`_0`, `vec_out[2]`→`_1`, `vec_out[1]`→`_2`, `vec_out[0]`→`_3`.
- `gate_in`  in  1  gate output (`_4`); combinational from `vec_out`, same clock domain, no synchronizer.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `pass`  out  1  `tt == EXPECTED_TT`; valid from `done` until the next accepted start.
- `tt`  out  16  captured truth table.
- `fail_count`  out  5  number of mismatching vectors, 0..16.
- `first_fail`  out  4  lowest vector index k that mismatched; 0 if none.

## Operation
- FSM states: IDLE, APPLY, DONE.
- IDLE + `start`=1 at an edge:
  - → APPLY.
  - k=0, `vec_out`=0, settle counter=0.
  - `tt`, `fail_count`, `first_fail`, `pass` cleared to 0.
  - `busy`=1.
- APPLY: hold `vec_out`=k for SETTLE+1 cycles (8-bit settle counter). On the edge ending the last cycle:
  - Write `gate_in` into `tt[15-k]`. Index k = {`_0`,`_1`,`_2`,`_3`}, `_0` MSB; hex MSB is vector 0.
  - If `gate_in` != `EXPECTED_TT[15-k]`: increment `fail_count`; if this is the first mismatch, load `first_fail`=k.
  - If k<15: k+1, settle counter=0.
  - If k=15: → DONE, `busy`=0, `done`=1, `pass` updated from final `tt`.
- DONE: lasts exactly one cycle, then → IDLE with `done`=0. `vec_out` returns to 0.
- `start` in APPLY or DONE: ignored, no queuing.
- `tt` updates bit-by-bit during the sweep and is observable mid-sweep. `pass` stays 0 until DONE.

## Timing
- Reset values (async on `rst_n`=0, and also during reset):
  - state IDLE.
  - `vec_out`=0, `busy`=0, `done`=0, `pass`=0.
  - `tt`=0, `fail_count`=0, `first_fail`=0.
- Start accepted at edge E0.
  - Vector k is driven during cycles E0+k(S+1)+1 .. E0+(k+1)(S+1), where S=SETTLE.
  - Vector k is sampled at edge E0+(k+1)(S+1).
- `done` is high in the cycle after edge E0+16(S+1).
  - Default S=2: sample at edge E0+48.
  - S=0: one cycle per vector, `done` after edge E0+16.
- Back-to-back: `start` held high continuously → the next sweep is accepted in the IDLE cycle following DONE.
- Reset mid-sweep: immediate abort, all outputs to reset values, no `done` pulse. A later `start` runs a full fresh sweep.
- `fail_count` saturates naturally at 16; it never wraps (5 bits).

## Test plan
- Reset: assert `rst_n`=0 mid-idle → all outputs 0. Release, no `start` → outputs stay 0 and `busy`=0.
- Golden model: `gate_in`=f(`vec_out`) for 0x10C9 (k=3,8,9,12,15 give 1), S=2, `start` at E0:
  - `done` at E0+48.
  - `tt`=16'h10C9, `pass`=1, `fail_count`=0, `first_fail`=0.
- `gate_in` tied 0 → `tt`=16'h0000, `pass`=0, `fail_count`=5, `first_fail`=3.
- `gate_in` tied 1 → `tt`=16'hFFFF, `pass`=0, `fail_count`=11, `first_fail`=0.
- Control:
  - `start` re-pulsed at E0+10 → ignored; `done` still at E0+48.
  - `rst_n` low at E0+20 → outputs 0, no `done`.
  - Fresh `start` afterwards → golden result 48 cycles later.
- SETTLE=0 with the golden model → `done` at E0+16, `pass`=1; `vec_out` steps 0..15 on consecutive cycles.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 input vectors through an external 4-input gate, rebuilds its
// truth table (vector 0 in the hex MSB) and compares it to a golden value.
module tt_sweep_checker #(
  parameter logic [15:0] EXPECTED_TT = 16'h10C9,
  parameter int          SETTLE      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  vec_out,
  input  logic        gate_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_t      state;
  logic [7:0]  settle_cnt;
  logic [15:0] tt_upd;
  logic [3:0]  bit_idx;
  logic        mismatch;

  // vec_out doubles as the vector index k; its sample lands in tt[15-k]
  always_comb begin
    bit_idx         = 4'd15 - vec_out;
    tt_upd          = tt;
    tt_upd[bit_idx] = gate_in;
    mismatch        = (gate_in != EXPECTED_TT[bit_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_out    <= 4'd0;
      settle_cnt <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      tt         <= 16'd0;
      fail_count <= 5'd0;
      first_fail <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= APPLY;
            vec_out    <= 4'd0;
            settle_cnt <= 8'd0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            tt         <= 16'd0;
            fail_count <= 5'd0;
            first_fail <= 4'd0;
          end
        end
        APPLY: begin
          if (settle_cnt == SETTLE_CNT) begin
            tt <= tt_upd;
            if (mismatch) begin
              fail_count <= fail_count + 5'd1;
              if (fail_count == 5'd0)
                first_fail <= vec_out;
            end
            // pass must reflect the final bit, so it is judged on tt_upd
            if (vec_out == 4'd15) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (tt_upd == EXPECTED_TT);
            end else begin
              vec_out    <= vec_out + 4'd1;
              settle_cnt <= 8'd0;
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          vec_out <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Randomized bench for tt_sweep_checker: a behavioural gate model drives
// gate_in and the expected results are derived from truth-table arithmetic.
module tb_tt_sweep_checker;

  localparam logic [15:0] GOLD = 16'h10C9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] cur_tt = GOLD;
  logic [3:0]  vec_a, vec_b, ff_a, ff_b;
  logic        gate_a, gate_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] tt_a, tt_b;
  logic [4:0]  fc_a, fc_b;
  bit          sel = 1'b0;
  int          n_compared = 0;
  int          n_mismatched = 0;

  logic [3:0]  o_vec, o_ff;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_fc;

  always #5 clk = ~clk;

  // The gate under test: output for vector k is bit 15-k of the current function
  assign gate_a = cur_tt[4'd15 - vec_a];
  assign gate_b = cur_tt[4'd15 - vec_b];

  tt_sweep_checker #(.EXPECTED_TT(GOLD), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_out(vec_a), .gate_in(gate_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .tt(tt_a),
    .fail_count(fc_a), .first_fail(ff_a)
  );

  tt_sweep_checker #(.EXPECTED_TT(GOLD), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_out(vec_b), .gate_in(gate_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .tt(tt_b),
    .fail_count(fc_b), .first_fail(ff_b)
  );

  assign o_vec  = sel ? vec_b  : vec_a;
  assign o_ff   = sel ? ff_b   : ff_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;
  assign o_tt   = sel ? tt_b   : tt_a;
  assign o_fc   = sel ? fc_b   : fc_a;

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({vec_a, busy_a, done_a, pass_a, tt_a, fc_a, ff_a} !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_values: got %h required 0",
               {vec_a, busy_a, done_a, pass_a, tt_a, fc_a, ff_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_compared++;
    if ({vec_a, busy_a, done_a, pass_a, tt_a, fc_a, ff_a} !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_after_reset: got %h required 0",
               {vec_a, busy_a, done_a, pass_a, tt_a, fc_a, ff_a});
    end
  endtask

  // One full sweep on the selected instance; repulse_at>0 re-raises start mid-sweep
  task automatic sweep(input bit which, input logic [15:0] func, input int repulse_at,
                       input string name);
    int          s = which ? 0 : 2;
    int          total = 16 * (s + 1);
    logic [15:0] diff;
    int          exp_cnt;
    int          exp_first;
    int          vec_bad = 0;
    int          done_early = 0;
    sel    = which;
    cur_tt = func;
    diff   = func ^ GOLD;
    exp_cnt = $countones(diff);
    exp_first = 0;
    for (int k = 15; k >= 0; k--)
      if (diff[15 - k]) exp_first = k;

    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    n_compared++;
    if (o_busy !== 1'b1 || o_tt !== 16'd0 || o_fc !== 5'd0 || o_pass !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL %s_accept: busy=%b tt=%h fc=%0d pass=%b required busy=1 rest 0",
               name, o_busy, o_tt, o_fc, o_pass);
    end
    for (int n = 1; n <= total; n++) begin
      @(posedge clk);
      #1;
      if (!which && n == repulse_at) start_a = 1'b1;
      else start_a = 1'b0;
      if (n < total) begin
        if (o_vec !== 4'(n / (s + 1))) vec_bad++;
        if (o_done !== 1'b0) done_early++;
      end
    end
    n_compared++;
    if (vec_bad != 0 || done_early != 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s_progress: vec errors=%0d early done=%0d required 0/0",
               name, vec_bad, done_early);
    end
    n_compared++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL %s_done_timing: done=%b busy=%b at cycle %0d required 1/0",
               name, o_done, o_busy, total);
    end
    n_compared++;
    if (o_tt !== func || o_pass !== (func == GOLD) || o_fc !== 5'(exp_cnt)
        || o_ff !== 4'(exp_first)) begin
      n_mismatched++;
      $display("[TB] FAIL %s_result: tt=%h pass=%b fc=%0d ff=%0d required tt=%h pass=%b fc=%0d ff=%0d",
               name, o_tt, o_pass, o_fc, o_ff, func, (func == GOLD), exp_cnt, exp_first);
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (o_done !== 1'b0 || o_pass !== (func == GOLD)) begin
      n_mismatched++;
      $display("[TB] FAIL %s_done_pulse: done=%b pass=%b required 0/%b",
               name, o_done, o_pass, (func == GOLD));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_patterns();
    sweep(1'b0, GOLD, 0, "golden");
    sweep(1'b0, 16'h0000, 0, "tied0");
    sweep(1'b0, 16'hFFFF, 0, "tied1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      sweep(1'b0, 16'($urandom_range(0, 65535)), 0, "random_a");
    sweep(1'b1, 16'($urandom_range(0, 65535)), 0, "random_b");
  endtask

  task automatic test_settle0();
    sweep(1'b1, GOLD, 0, "settle0");
  endtask

  task automatic test_control();
    int done_seen = 0;
    sweep(1'b0, GOLD, 10, "repulse");
    sel    = 1'b0;
    cur_tt = GOLD;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({vec_a, busy_a, done_a, pass_a, tt_a, fc_a, ff_a} !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL midsweep_reset: got %h required 0",
               {vec_a, busy_a, done_a, pass_a, tt_a, fc_a, ff_a});
    end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) rst_n = 1'b1;
      if (done_a !== 1'b0 || busy_a !== 1'b0) done_seen++;
    end
    n_compared++;
    if (done_seen != 0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_no_done: got %0d active cycles required 0", done_seen);
    end
    sweep(1'b0, GOLD, 0, "fresh_after_reset");
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    sel    = 1'b0;
    cur_tt = GOLD;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 98; n++) begin
      @(posedge clk);
      #1;
      if (n == 48 && done_a !== 1'b1) errs++;
      if (n == 49 && (done_a !== 1'b0 || busy_a !== 1'b0)) errs++;
      if (n == 50 && (busy_a !== 1'b1 || tt_a !== 16'd0)) errs++;
      if (n == 98 && (done_a !== 1'b1 || tt_a !== GOLD || pass_a !== 1'b1)) errs++;
      if (n != 48 && n != 98 && done_a !== 1'b0) errs++;
    end
    start_a = 1'b0;
    n_compared++;
    if (errs != 0) begin
      n_mismatched++;
      $display("[TB] FAIL back_to_back: got %0d timing errors required 0", errs);
    end
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if (busy_a !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL back_to_back_idle: busy=%b required 0", busy_a);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_patterns();
    test_settle0();
    test_random();
    test_control();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
